// File: rtl/bash_f_const_gen.sv
// ---------------------------------------------------------------------------
// bash_f_const_gen
//
// Generates the round-constant sequence of the bash-f permutation. Each
// constant is derived from the previous one by a Galois-style LFSR step:
//   x' = (x >> 1) ^ (x[0] ? POLY : 0)
// evaluated on the integer view of the word. With BYTE_SWAP=1 the words are
// carried byte-reversed (little-endian byte order), both in the internal
// register and on c_o.
//
// LANES constants are presented per beat. Lane 0 comes from the register and
// the remaining lanes are produced by an unrolled combinational chain of
// steps. A beat is accepted when valid_o && ready_i.
//
// Optional feature macro: BASH_F_CONST_GEN_SEED_EN
//   defined   : extra input seed_i (same encoding as c_o) is loaded on start
//   undefined : C_INIT is always loaded on start
//
// Ports:
//   clk_i    in   1            clock
//   rst_ni   in   1            asynchronous active-low reset
//   start_i  in   1            begin a new sequence (only sampled in IDLE)
//   seed_i   in   SLEN         start seed (only with BASH_F_CONST_GEN_SEED_EN)
//   ready_o  out  1            idle, a start would be accepted
//   c_o      out  LANES*SLEN   constants, lane k = constant index round_o+k
//   valid_o  out  1            c_o holds a valid beat
//   ready_i  in   1            consumer accepts the current beat
//   round_o  out  RW           index of the lane 0 constant
//   last_o   out  1            current beat holds constant ROUNDS-1
//   done_o   out  1            one-cycle pulse after the final beat accepted
// ---------------------------------------------------------------------------
module bash_f_const_gen #(
  parameter int              SLEN      = 64,
  parameter int              LANES     = 1,
  parameter int              ROUNDS    = 24,
  parameter logic [SLEN-1:0] C_INIT    = 64'h3BF5080AC8BA94B1,
  // bash-f LFSR feedback constant
  parameter logic [SLEN-1:0] POLY      = 64'hAED8E07F99E12BDC,
  parameter int              BYTE_SWAP = 1,
  localparam int             RW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
`ifdef BASH_F_CONST_GEN_SEED_EN
  input  logic [SLEN-1:0]       seed_i,
`endif
  output logic                  ready_o,
  output logic [LANES*SLEN-1:0] c_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [RW-1:0]         round_o,
  output logic                  last_o,
  output logic                  done_o
);

  // Reject configurations that cannot produce whole beats or whole bytes.
  if ((ROUNDS % LANES) != 0) begin : g_bad_rounds
    $error("bash_f_const_gen: ROUNDS must be a multiple of LANES");
  end
  if ((SLEN % 8) != 0) begin : g_bad_slen
    $error("bash_f_const_gen: SLEN must be a multiple of 8");
  end

  function automatic logic [SLEN-1:0] byte_rev(input logic [SLEN-1:0] w);
    logic [SLEN-1:0] r;
    r = '0;
    for (int i = 0; i < SLEN / 8; i++) begin
      r[i*8 +: 8] = w[(SLEN/8-1-i)*8 +: 8];
    end
    return r;
  endfunction

  // One LFSR step on an encoded word: decode to integer order, shift with
  // conditional feedback, then re-encode.
  function automatic logic [SLEN-1:0] step(input logic [SLEN-1:0] w);
    logic [SLEN-1:0] x;
    x = (BYTE_SWAP != 0) ? byte_rev(w) : w;
    x = (x >> 1) ^ (x[0] ? POLY : '0);
    return (BYTE_SWAP != 0) ? byte_rev(x) : x;
  endfunction

  localparam logic [SLEN-1:0] SEED_RESET = (BYTE_SWAP != 0) ? byte_rev(C_INIT) : C_INIT;
  localparam logic [RW-1:0]   LAST_ROUND = RW'(ROUNDS - LANES);
  localparam logic [RW-1:0]   ROUND_INC  = RW'(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [SLEN-1:0] word;
  logic [RW-1:0]   round;
  logic            done;
  logic [SLEN-1:0] chain;
  logic [SLEN-1:0] next_word;
  logic [SLEN-1:0] seed_load;
  logic            at_last;

`ifdef BASH_F_CONST_GEN_SEED_EN
  assign seed_load = seed_i;
`else
  assign seed_load = SEED_RESET;
`endif

  // Unrolled lane chain: lane k is the register stepped k times; one more
  // step past the last lane gives the lane 0 value of the next beat.
  always_comb begin
    chain = word;
    c_o   = '0;
    for (int k = 0; k < LANES; k++) begin
      c_o[k*SLEN +: SLEN] = chain;
      chain = step(chain);
    end
    next_word = chain;
  end

  assign at_last = (round == LAST_ROUND);

  // The counter is not advanced on the final beat, so it can never wrap
  // even when ROUNDS is a power of two; it is only cleared by a start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      word  <= SEED_RESET;
      round <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            word  <= seed_load;
            round <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (ready_i) begin
            word <= next_word;
            if (at_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              round <= round + ROUND_INC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == RUN);
  assign last_o  = at_last && (state == RUN);
  assign round_o = round;
  assign done_o  = done;

endmodule

// File: tb/tb_bash_f_const_gen.sv
// ---------------------------------------------------------------------------
// tb_bash_f_const_gen
//
// Two generator instances share clock and reset:
//   dut_a : LANES=1, BYTE_SWAP=0 (plain integer order)
//   dut_b : LANES=4, BYTE_SWAP=1 (byte-reversed words)
// Stimulus pushes the expected beats into a per-instance queue; a monitor per
// instance pops and compares whenever that instance presents a beat.
// ---------------------------------------------------------------------------
module tb_bash_f_const_gen;

  localparam logic [63:0] C_INIT     = 64'h3BF5080AC8BA94B1;
  localparam logic [63:0] POLY       = 64'hAED8E07F99E12BDC;
  localparam logic [63:0] HAND_BEAT1 = 64'hB322647AFDBC6184;
  localparam int          ROUNDS     = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, ready_in_a, ready_a, valid_a, last_a, done_a;
  logic [63:0] c_a;
  logic [4:0]  round_a;

  logic         start_b, ready_in_b, ready_b, valid_b, last_b, done_b;
  logic [255:0] c_b;
  logic [4:0]   round_b;

`ifdef BASH_F_CONST_GEN_SEED_EN
  logic [63:0] seed_a, seed_b;
`endif

  bash_f_const_gen #(.LANES(1), .BYTE_SWAP(0)) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_a),
`ifdef BASH_F_CONST_GEN_SEED_EN
    .seed_i  (seed_a),
`endif
    .ready_o (ready_a),
    .c_o     (c_a),
    .valid_o (valid_a),
    .ready_i (ready_in_a),
    .round_o (round_a),
    .last_o  (last_a),
    .done_o  (done_a)
  );

  bash_f_const_gen #(.LANES(4), .BYTE_SWAP(1)) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_b),
`ifdef BASH_F_CONST_GEN_SEED_EN
    .seed_i  (seed_b),
`endif
    .ready_o (ready_b),
    .c_o     (c_b),
    .valid_o (valid_b),
    .ready_i (ready_in_b),
    .round_o (round_b),
    .last_o  (last_b),
    .done_o  (done_b)
  );

  typedef struct {
    logic [255:0] c;
    logic [7:0]   round;
    logic         last;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];
  int    checks = 0;
  int    errors = 0;
  bit    done_exp_a = 1'b0;
  bit    done_exp_b = 1'b0;

  function automatic logic [63:0] step_int(input logic [63:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 64'h0);
  endfunction

  function automatic logic [63:0] byte_rev64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(7-i)*8 +: 8];
    return r;
  endfunction

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Build the integer-order sequence from the seed and queue the expected
  // beats for the selected instance. Beat 1 of the default seed is the
  // hand-computed reference value.
  task automatic pushExpect(input int sel, input logic [63:0] init);
    logic [63:0] seq [ROUNDS];
    beat_t b;
    seq[0] = init;
    seq[1] = (init == C_INIT) ? HAND_BEAT1 : step_int(init);
    for (int i = 2; i < ROUNDS; i++) seq[i] = step_int(seq[i-1]);
    if (sel == 0) begin
      for (int i = 0; i < ROUNDS; i++) begin
        b.c     = {192'h0, seq[i]};
        b.round = 8'(i);
        b.last  = (i == ROUNDS - 1);
        q_a.push_back(b);
      end
    end else begin
      for (int j = 0; j < ROUNDS / 4; j++) begin
        b.c = '0;
        for (int k = 0; k < 4; k++) b.c[k*64 +: 64] = byte_rev64(seq[4*j+k]);
        b.round = 8'(4 * j);
        b.last  = (j == ROUNDS / 4 - 1);
        q_b.push_back(b);
      end
    end
  endtask

  task automatic setStart(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic setReady(input int sel, input logic v);
    if (sel == 0) ready_in_a = v; else ready_in_b = v;
  endtask

  function automatic logic isDone(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " A valid_o"}, valid_a, 1'b0);
    checkOutput({tag, " A ready_o"}, ready_a, 1'b1);
    checkOutput({tag, " A last_o"}, last_a, 1'b0);
    checkOutput({tag, " A done_o"}, done_a, 1'b0);
    checkOutput({tag, " A round_o"}, round_a, 5'd0);
    checkOutput({tag, " A c_o"}, c_a, C_INIT);
    checkOutput({tag, " B valid_o"}, valid_b, 1'b0);
    checkOutput({tag, " B ready_o"}, ready_b, 1'b1);
    checkOutput({tag, " B last_o"}, last_b, 1'b0);
    checkOutput({tag, " B done_o"}, done_b, 1'b0);
    checkOutput({tag, " B round_o"}, round_b, 5'd0);
    checkOutput({tag, " B c_o lane0"}, c_b[63:0], byte_rev64(C_INIT));
  endtask

  // Mid-sequence abort: outputs must drop to reset values at once, the
  // pending beats are discarded and the first cycle after release is IDLE.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkResetValues("mid-run reset");
    q_a.delete();
    q_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset A ready_o", ready_a, 1'b1);
    checkOutput("post-reset A valid_o", valid_a, 1'b0);
    checkOutput("post-reset A done_o", done_a, 1'b0);
  endtask

  // Issue one start and follow the sequence until done_o. Inputs change 1
  // time unit after the rising edge; cnt counts edges after the start edge.
  // Optional: hold start high in RUN, stall ready_i, or reset at a beat.
  task automatic applyStimulus(input int sel, input logic [63:0] init, input int start_hold,
                               input int stall_at, input int stall_len, input int reset_at,
                               input int exp_cycles);
    int cnt;
    cnt = 0;
    pushExpect(sel, init);
    setStart(sel, 1'b1);
    @(posedge clk); #1;
    while (cnt < 300) begin
      if (cnt >= start_hold) setStart(sel, 1'b0);
      @(posedge clk); #1;
      cnt++;
      if (cnt == stall_at) setReady(sel, 1'b0);
      if (cnt == stall_at + stall_len) setReady(sel, 1'b1);
      if (cnt == reset_at) begin
        applyReset();
        return;
      end
      if (isDone(sel)) break;
    end
    setStart(sel, 1'b0);
    setReady(sel, 1'b1);
    checkOutput((sel == 0) ? "A cycles to done_o" : "B cycles to done_o", cnt, exp_cycles);
  endtask

  // Monitor A: compares the presented beat with the queue head every cycle
  // (so a stalled beat must stay frozen), pops on acceptance, and expects
  // done_o exactly one cycle after the final beat is accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp_a = 1'b0;
    end else begin
      if (done_exp_a) begin
        checkOutput("A done_o", done_a, 1'b1);
        done_exp_a = 1'b0;
      end else if (done_a) begin
        checkOutput("A done_o spurious", done_a, 1'b0);
      end
      if (valid_a) begin
        if (q_a.size() == 0) begin
          checkOutput("A unexpected beat", valid_a, 1'b0);
        end else begin
          checkOutput("A c_o", c_a, q_a[0].c);
          checkOutput("A round_o", round_a, q_a[0].round);
          checkOutput("A last_o", last_a, q_a[0].last);
          if (ready_in_a) begin
            if (q_a[0].last) done_exp_a = 1'b1;
            void'(q_a.pop_front());
          end
        end
      end
    end
  end

  // Monitor B: same checks for the four-lane byte-reversed instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp_b = 1'b0;
    end else begin
      if (done_exp_b) begin
        checkOutput("B done_o", done_b, 1'b1);
        done_exp_b = 1'b0;
      end else if (done_b) begin
        checkOutput("B done_o spurious", done_b, 1'b0);
      end
      if (valid_b) begin
        if (q_b.size() == 0) begin
          checkOutput("B unexpected beat", valid_b, 1'b0);
        end else begin
          checkOutput("B c_o", c_b, q_b[0].c);
          checkOutput("B round_o", round_b, q_b[0].round);
          checkOutput("B last_o", last_b, q_b[0].last);
          if (ready_in_b) begin
            if (q_b[0].last) done_exp_b = 1'b1;
            void'(q_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    ready_in_a = 1'b1;
    ready_in_b = 1'b1;
`ifdef BASH_F_CONST_GEN_SEED_EN
    seed_a = C_INIT;
    seed_b = byte_rev64(C_INIT);
`endif
    #2 rst_n = 1'b0;
    #1 checkResetValues("power-on reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full LANES=1 sequence, consumer always ready.
    applyStimulus(0, C_INIT, 0, -1, 0, -1, 24);
    // LANES=4 byte-swapped sequence with start held high into RUN, then a
    // second one started on the done_o cycle.
    applyStimulus(1, C_INIT, 3, -1, 0, -1, 6);
    applyStimulus(1, C_INIT, 0, -1, 0, -1, 6);
    // Consumer stalls for 3 cycles while beat 5 is presented.
    applyStimulus(0, C_INIT, 0, 5, 3, -1, 27);
    // Reset while beat 10 is presented, then a clean restart.
    applyStimulus(0, C_INIT, 0, -1, 0, 10, 0);
    applyStimulus(0, C_INIT, 0, -1, 0, -1, 24);
`ifdef BASH_F_CONST_GEN_SEED_EN
    // Seed of integer 1: beat 1 is POLY; two sequences back-to-back.
    seed_a = 64'h1;
    applyStimulus(0, 64'h1, 0, -1, 0, -1, 24);
    applyStimulus(0, 64'h1, 0, -1, 0, -1, 24);
    seed_a = C_INIT;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("A queue drained", q_a.size(), 0);
    checkOutput("B queue drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
